// File: rtl/alu_arb_ctrl.sv
// Two-channel arbiter/sequencer for one shared combinational 4-bit ALU.
// One op in flight: IDLE accepts, EXEC lets the ALU settle, RESP holds the result until taken.
module alu_arb_ctrl #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic [5:0] req_op,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       busy,
    output logic [7:0] done_cnt
);

    localparam int NUM_CH = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                        state;
    logic                          owner;
    logic                          last_owner;
    logic                          g;
    logic [NUM_CH-1:0][3:0]        ch_a;
    logic [NUM_CH-1:0][3:0]        ch_b;
    logic [NUM_CH-1:0][2:0]        ch_op;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_a[i]  = req_a[4*i +: 4];
        assign ch_b[i]  = req_b[4*i +: 4];
        assign ch_op[i] = req_op[3*i +: 3];
    end

    // On a tie, round-robin hands the grant to whichever channel did not finish last.
    always_comb begin
        g = 1'b0;
        case (req_valid)
            2'b01:   g = 1'b0;
            2'b10:   g = 1'b1;
            2'b11:   g = RR_EN ? ~last_owner : 1'b0;
            default: g = 1'b0;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && rst_n)
            req_ready[g] = req_valid[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            busy       <= 1'b0;
            done_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        alu_a  <= ch_a[g];
                        alu_b  <= ch_b[g];
                        alu_op <= ch_op[g];
                        owner  <= g;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_carry  <= alu_carry;
                    rsp_zero   <= alu_zero;
                    rsp_valid  <= owner ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid  <= '0;
                        last_owner <= owner;
                        done_cnt   <= done_cnt + 8'd1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arb_ctrl.md
# alu_arb_ctrl

Two-channel arbiter and sequencer for a single shared `alu_4bit` instance. It accepts operation requests (A, B, op code) from two requesters over valid/ready handshakes and grants the ALU by round-robin or fixed priority. It drives the ALU from registered operands, captures the ALU outputs one cycle later, and returns the result to the owning channel over a valid/ready response handshake. It sits between the requesting blocks and the ALU, which stays purely combinational.

## Interface
- `RR_EN`, default 1: 1 = round-robin arbitration; 0 = fixed priority, channel 0 always wins.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: bit i = channel i has a request.
- `req_ready` out 2: bit i = channel i request is accepted this cycle.
- `req_a` in 8: operand A; channel i is at [4i+3:4i].
- `req_b` in 8: operand B; same packing as `req_a`.
- `req_op` in 6: op code; channel i is at [3i+2:3i]; encoding is the ALU's (000 add … 111 shr).
- `rsp_valid` out 2: one-hot; bit i = response for channel i is pending.
- `rsp_ready` in 2: bit i = channel i takes its response.
- `rsp_result` out 4: captured ALU result.
- `rsp_carry` out 1: captured ALU carry_out.
- `rsp_zero` out 1: captured ALU zero.
- `alu_a`, `alu_b` out 4 each: to ALU A/B, driven from registers.
- `alu_op` out 3: to ALU op_code, driven from a register.
- `alu_result` in 4, `alu_carry` in 1, `alu_zero` in 1: from the ALU.
- `busy` out 1: high in any state other than IDLE.
- `done_cnt` out 8: count of completed responses; wraps 255 -> 0.

## Operation
- FSM states: IDLE, EXEC, RESP. Exactly one operation is outstanding at a time.
- IDLE: the selected channel `g` is computed combinationally from `req_valid`. `req_ready[g]` = 1 only when `req_valid[g]` = 1; the other ready bit is 0.
  - On handshake, latch `req_a`/`req_b`/`req_op` of `g` into `alu_a`/`alu_b`/`alu_op`, store `owner` = g, go to EXEC.
- Selection:
  - Exactly one channel valid: that channel is selected.
  - Both valid with `RR_EN`=1: the channel not equal to `last_owner` is selected.
  - Both valid with `RR_EN`=0: channel 0 is selected.
  - `last_owner` resets to 1, so channel 0 wins the first tie.
- EXEC (exactly 1 cycle): ALU inputs are stable. At the end of the cycle, capture `alu_result`/`alu_carry`/`alu_zero` into the `rsp_*` registers, then go to RESP.
- RESP: `rsp_valid[owner]` = 1.
  - `rsp_*` outputs hold stable until `rsp_ready[owner]` = 1.
  - On that handshake: clear `rsp_valid`, set `last_owner` = owner, increment `done_cnt`, go to IDLE.
  - `rsp_ready` of the non-owner channel is ignored.
- `req_ready` is 0 in EXEC and RESP. Requests stay pending and must be held stable by the requester.
- The ALU's arithmetic and flags are passed through unmodified; the block adds no width extension.
- Requesters must not make `req_valid` depend on `req_ready` (ready depends combinationally on valid).

## Timing
- Reset values:
  - `rsp_valid`=00, `req_ready`=00, `busy`=0.
  - `rsp_result`=0, `rsp_carry`=0, `rsp_zero`=0.
  - `alu_a`=`alu_b`=0, `alu_op`=000.
  - `done_cnt`=0, state=IDLE, `last_owner`=1.
- Latency: request accepted at edge N -> EXEC in cycle N..N+1 -> `rsp_valid` high after edge N+1.
  - If `rsp_ready` is already high, the response completes at edge N+2.
  - Next accept is no earlier than the cycle after edge N+2, so peak rate is 1 op / 3 cycles.
- Backpressure: RESP may last any number of cycles with all outputs frozen.
- `rst_n` low in any state returns to IDLE immediately. Any in-flight operation is discarded, no response is issued, and `done_cnt` is not incremented.
- `rst_n` deassertion is synchronised externally. The first accept can occur on the first edge after release.

## Test plan
- Ch0 only, A=0101 B=0011 op=000, `rsp_ready`=1 -> accepted, `rsp_valid`=01 two edges later, result=1000, zero=0, `done_cnt`=1.
- Ch0 A=1001 B=1000 op=000 -> result=0001, carry=1. Ch1 A=0101 B=0101 op=001 -> result=0000, zero=1 on `rsp_valid`=10.
- Both channels continuously valid, 4 ops, `RR_EN`=1 -> grant order 0,1,0,1. With `RR_EN`=0 -> 0,0,0,0; ch1 stays unacked.
- Hold `rsp_ready`=00 for 5 cycles in RESP -> `rsp_*` stable, `req_ready`=00, `busy`=1. Then raise `rsp_ready[owner]` -> completes in 1 cycle; asserting only the non-owner bit does nothing.
- Assert `rst_n`=0 during EXEC -> all outputs take reset values immediately, no response after release, `done_cnt`=0.
- Run 256 completed ops -> `done_cnt` wraps to 0.
